// File: rtl/data_mem_pkg.sv
// Shared constants and types for the two-requestor data memory.
package data_mem_pkg;

  localparam int ADDR_W_DEF   = 8;
  localparam int DATA_W_DEF   = 128;
  localparam int STARVE_DEF   = 4;
  localparam int STARVE_CNT_W = 4;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

endpackage

// File: rtl/data_mem_arb.sv
// Fixed-priority grant for port A with a starvation counter that forces port B through.
module data_mem_arb
  import data_mem_pkg::*;
#(
  parameter int STARVE = STARVE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic a_req_i,
  input  logic b_req_i,
  output logic a_gnt_o,
  output logic b_gnt_o
);

  logic [STARVE_CNT_W-1:0] starve_q, starve_d;
  logic                    force_b;

  always_comb begin
    force_b  = (starve_q == STARVE_CNT_W'(STARVE)) && b_req_i;
    // Grants are held low while reset is asserted, whatever the requests do.
    a_gnt_o  = a_req_i && !force_b && !rst;
    b_gnt_o  = b_req_i && (force_b || !a_req_i) && !rst;
    starve_d = starve_q;
    if (b_req_i && !b_gnt_o) begin
      if (starve_q != STARVE_CNT_W'(STARVE)) starve_d = starve_q + 1'b1;
    end else begin
      starve_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end

endmodule

// File: rtl/data_mem_arb2.sv
// Shared single-port data array serving a priority core port (A) and a DMA/host port (B).
module data_mem_arb2
  import data_mem_pkg::*;
#(
  parameter  int ADDR_W = ADDR_W_DEF,
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int STARVE = STARVE_DEF,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  output logic              a_gnt,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [BE_W-1:0]   a_be,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  output logic              b_gnt,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [BE_W-1:0]   b_be,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  logic              acc, acc_we;
  port_e             acc_port;
  logic [ADDR_W-1:0] acc_addr;
  logic [BE_W-1:0]   acc_be;
  logic [DATA_W-1:0] acc_wdata;

  logic              s1_vld_q, s2_vld_q;
  port_e             s1_tag_q, s2_tag_q;
  logic [ADDR_W-1:0] s1_addr_q;
  logic [DATA_W-1:0] s2_data_q;

  logic              a_rvalid_q, b_rvalid_q;
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

  data_mem_arb #(.STARVE(STARVE)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .a_req_i (a_req),
    .b_req_i (b_req),
    .a_gnt_o (a_gnt),
    .b_gnt_o (b_gnt)
  );

  always_comb begin
    acc       = a_gnt || b_gnt;
    acc_port  = PORT_A;
    acc_we    = a_we;
    acc_addr  = a_addr;
    acc_be    = a_be;
    acc_wdata = a_wdata;
    if (b_gnt) begin
      acc_port  = PORT_B;
      acc_we    = b_we;
      acc_addr  = b_addr;
      acc_be    = b_be;
      acc_wdata = b_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (acc && acc_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (acc_be[i]) mem_q[acc_addr][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  // Stage 1: capture accepted read address and owning port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_tag_q <= PORT_A;
    end else begin
      s1_vld_q <= acc && !acc_we;
      s1_tag_q <= acc_port;
    end
  end

  always_ff @(posedge clk) begin
    if (acc && !acc_we) s1_addr_q <= acc_addr;
  end

  // Registered array read; sees every write committed up to the previous edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_vld_q <= 1'b0;
      s2_tag_q <= PORT_A;
    end else begin
      s2_vld_q <= s1_vld_q;
      s2_tag_q <= s1_tag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_vld_q) s2_data_q <= mem_q[s1_addr_q];
  end

  // Stage 2 output: only the owning port's rdata moves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      a_rvalid_q <= s2_vld_q && (s2_tag_q == PORT_A);
      b_rvalid_q <= s2_vld_q && (s2_tag_q == PORT_B);
      if (s2_vld_q && (s2_tag_q == PORT_A)) a_rdata_q <= s2_data_q;
      if (s2_vld_q && (s2_tag_q == PORT_B)) b_rdata_q <= s2_data_q;
    end
  end

  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_data_mem_arb2.sv
// Directed bench for data_mem_arb2 with a transaction-level reference model checked every cycle.
module tb_data_mem_arb2;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 128;
  localparam int BE_W   = 16;
  localparam int STARVE = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [ADDR_W-1:0] a_addr = '0, b_addr = '0;
  logic [BE_W-1:0]   a_be = '0, b_be = '0;
  logic [DATA_W-1:0] a_wdata = '0, b_wdata = '0;
  logic              a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [DATA_W-1:0] a_rdata, b_rdata;

  always #5 clk = ~clk;

  data_mem_arb2 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE(STARVE)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_gnt(a_gnt), .a_we(a_we), .a_addr(a_addr), .a_be(a_be),
    .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_gnt(b_gnt), .b_we(b_we), .b_addr(b_addr), .b_be(b_be),
    .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: a word array, a starve count and a queue of due read responses.
  typedef struct {
    int               due;
    bit               port;
    logic [DATA_W-1:0] data;
  } rsp_t;

  rsp_t              pend[$];
  logic [DATA_W-1:0] mdl_mem [256];
  int                cyc = 0;
  int                m_starve = 0;
  logic              m_arv = 1'b0, m_brv = 1'b0;
  logic [DATA_W-1:0] m_ard = '0, m_brd = '0;
  bit                m_fb, m_ga, m_gb;
  bit                cmp_en = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_starve = 0;
      pend.delete();
      m_arv = 1'b0; m_brv = 1'b0;
      m_ard = '0;   m_brd = '0;
    end else begin
      m_fb = (m_starve == STARVE) && b_req;
      m_ga = a_req && !m_fb;
      m_gb = b_req && (m_fb || !a_req);
      m_arv = 1'b0; m_brv = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        if (pend[0].port) begin m_brv = 1'b1; m_brd = pend[0].data; end
        else              begin m_arv = 1'b1; m_ard = pend[0].data; end
        void'(pend.pop_front());
      end
      if (m_ga) begin
        if (a_we) begin
          for (int i = 0; i < BE_W; i++) if (a_be[i]) mdl_mem[a_addr][8*i +: 8] = a_wdata[8*i +: 8];
        end else pend.push_back('{cyc + 2, 1'b0, mdl_mem[a_addr]});
      end
      if (m_gb) begin
        if (b_we) begin
          for (int i = 0; i < BE_W; i++) if (b_be[i]) mdl_mem[b_addr][8*i +: 8] = b_wdata[8*i +: 8];
        end else pend.push_back('{cyc + 2, 1'b1, mdl_mem[b_addr]});
      end
      if (b_req && !m_gb) m_starve = (m_starve < STARVE) ? m_starve + 1 : STARVE;
      else                m_starve = 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      if (rst) begin
        chk("rst_a_gnt", a_gnt, 0);    chk("rst_b_gnt", b_gnt, 0);
        chk("rst_a_rvalid", a_rvalid, 0); chk("rst_b_rvalid", b_rvalid, 0);
        chk("rst_a_rdata", a_rdata, 0);   chk("rst_b_rdata", b_rdata, 0);
      end else begin
        chk("a_gnt", a_gnt, a_req && !((m_starve == STARVE) && b_req));
        chk("b_gnt", b_gnt, b_req && (((m_starve == STARVE) && b_req) || !a_req));
        chk("a_rvalid", a_rvalid, m_arv);
        chk("b_rvalid", b_rvalid, m_brv);
        chk("a_rdata", a_rdata, m_ard);
        chk("b_rdata", b_rdata, m_brd);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic access(input bit port, input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [BE_W-1:0] be, input logic [DATA_W-1:0] wd);
    bit got = 0;
    if (port) begin b_req = 1; b_we = we; b_addr = addr; b_be = be; b_wdata = wd; end
    else      begin a_req = 1; a_we = we; a_addr = addr; a_be = be; a_wdata = wd; end
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = port ? b_gnt : a_gnt;
      @(posedge clk); #1;
    end
    if (port) b_req = 0; else a_req = 0;
    chk("grant_timeout", got, 1);
  endtask

  // Counts negedges until the port's rvalid, checks data, then realigns to posedge+1.
  task automatic wait_rv(input bit port, input logic [DATA_W-1:0] exp, input string name,
                         output int lat);
    bit seen = 0;
    lat = 0;
    for (int n = 1; n <= 10 && !seen; n++) begin
      @(negedge clk);
      seen = port ? b_rvalid : a_rvalid;
      lat = n;
    end
    chk({name, "_seen"}, seen, 1);
    chk(name, port ? b_rdata : a_rdata, exp);
    @(posedge clk); #1;
  endtask

  localparam logic [DATA_W-1:0] PAT  = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [DATA_W-1:0] ONES = {DATA_W{1'b1}};

  initial begin
    int lat;
    int cnt;
    // Reset with requests raised: grants must stay low.
    a_req = 1; b_req = 1;
    repeat (2) @(posedge clk);
    #1 cmp_en = 1;
    @(negedge clk);
    chk("lit_rst_a_gnt", a_gnt, 0);
    chk("lit_rst_b_rdata", b_rdata, 0);
    @(posedge clk); #1;
    a_req = 0; b_req = 0; rst = 0;

    // Full write and read, latency two edges.
    access(0, 1, 8'h10, '1, PAT);
    access(0, 0, 8'h10, '0, '0);
    wait_rv(0, PAT, "lit_pattern", lat);
    chk("lit_latency", lat, 3);
    chk("lit_b_rvalid_quiet", b_rvalid, 0);

    // Byte-enable partial write.
    access(0, 1, 8'h20, '1, ONES);
    access(0, 1, 8'h20, 16'h0001, 128'hAB);
    access(0, 0, 8'h20, '0, '0);
    wait_rv(0, {{(DATA_W-8){1'b1}}, 8'hAB}, "lit_partial", lat);

    // Contention: A reads every cycle, B forced through on its 5th request cycle.
    a_req = 1; a_we = 0; a_addr = 8'h10;
    b_req = 1; b_we = 0; b_addr = 8'h20;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk($sformatf("lit_cont_b_gnt_%0d", k), b_gnt, (k == 5));
      chk($sformatf("lit_cont_a_gnt_%0d", k), a_gnt, (k != 5));
      @(posedge clk); #1;
      if (k == 5) b_req = 0;
    end
    b_req = 1;
    @(negedge clk);
    chk("lit_starve_cleared", b_gnt, 0);
    @(posedge clk); #1;
    a_req = 0; b_req = 0;
    repeat (4) @(posedge clk);
    #1;

    // Back-to-back reads.
    access(0, 1, 8'h01, '1, {16{8'h11}});
    access(0, 1, 8'h02, '1, {16{8'h22}});
    access(0, 1, 8'h03, '1, {16{8'h33}});
    a_req = 1; a_we = 0; a_addr = 8'h01;
    @(posedge clk); #1 a_addr = 8'h02;
    @(posedge clk); #1 a_addr = 8'h03;
    @(posedge clk); #1 a_req = 0;
    for (int k = 1; k <= 3; k++) begin
      logic [7:0] bv;
      bv = 8'(k * 17);
      @(negedge clk);
      chk($sformatf("lit_b2b_valid_%0d", k), a_rvalid, 1);
      chk($sformatf("lit_b2b_data_%0d", k), a_rdata, {16{bv}});
    end
    @(posedge clk); #1;

    // Write on A then read on B the very next cycle.
    access(0, 1, 8'h30, '1, {16{8'h55}});
    access(1, 0, 8'h30, '0, '0);
    wait_rv(1, {16{8'h55}}, "lit_coherent_b", lat);
    chk("lit_a_rdata_kept", a_rdata, {16{8'h33}});

    // Reset one cycle after a read is accepted: the response is dropped.
    access(0, 0, 8'h10, '0, '0);
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    chk("lit_midrst_rdata", a_rdata, 0);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (a_rvalid) cnt++;
    end
    chk("lit_dropped_rsp", cnt, 0);
    @(posedge clk); #1;
    access(0, 0, 8'h10, '0, '0);
    wait_rv(0, PAT, "lit_mem_kept", lat);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
